led_sequencer: RTL

- Parametrised successor to the board's free-running LED counter.
- A prescaler derives a step strobe from the board clock; each step advances an N_LEDS-wide display pattern in one of four modes: binary up, binary down, Gray, or bounce.
- Run and mode come from asynchronous pins and are synchronised internally.
- The block drives CPLD LED pins directly and serves as the bring-up and heartbeat indicator.

---
 rtl/led_sequencer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/led_sequencer.sv
// Prescaled LED pattern sequencer: up/down/Gray counters and a one-hot bounce,
// driven by synchronised run/mode pins and emitting a tick with each new pattern.
module led_sequencer #(
  parameter int N_LEDS        = 4,
  parameter int PRESCALE_BITS = 10,
  parameter int SYNC_STAGES   = 2
) (
  input  logic              pG0,
  input  logic              p3B2,
  input  logic              run,
  input  logic [1:0]        mode,
  output logic [N_LEDS-1:0] led,
  output logic              tick
);

  localparam int PRE_W = (PRESCALE_BITS > 0) ? PRESCALE_BITS : 1;
  localparam int POS_W = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;

  localparam logic [1:0] M_UP     = 2'b00;
  localparam logic [1:0] M_DOWN   = 2'b01;
  localparam logic [1:0] M_GRAY   = 2'b10;
  localparam logic [1:0] M_BOUNCE = 2'b11;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  localparam logic [POS_W-1:0] POS_MAX = POS_W'(N_LEDS - 1);

  function automatic logic [N_LEDS-1:0] onehot(input logic [POS_W-1:0] p);
    return N_LEDS'(1'b1) << p;
  endfunction

  function automatic logic [N_LEDS-1:0] bin2gray(input logic [N_LEDS-1:0] n);
    return n ^ (n >> 1);
  endfunction

  logic [SYNC_STAGES-1:0]      run_sync_q, run_sync_d;
  logic [SYNC_STAGES-1:0][1:0] mode_sync_q, mode_sync_d;
  logic                        run_s;
  logic [1:0]                  mode_s;

  logic [PRE_W-1:0]  pre_q, pre_d;
  logic              step;
  logic [N_LEDS-1:0] cnt_q, cnt_d, cnt_inc, cnt_dec;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic              dir_q, dir_d;
  logic [1:0]        m_q, m_d;
  logic [N_LEDS-1:0] led_q, led_d;
  logic              tick_q, tick_d;

  // Synchroniser chains: stage 0 samples the pin, the last stage is the usable value
  always_comb begin
    run_sync_d  = {run_sync_q[SYNC_STAGES-2:0], run};
    mode_sync_d = {mode_sync_q[SYNC_STAGES-2:0], mode};
  end

  assign run_s  = run_sync_q[SYNC_STAGES-1];
  assign mode_s = mode_sync_q[SYNC_STAGES-1];

  always_comb begin
    pre_d = pre_q;
    step  = 1'b0;
    if (PRESCALE_BITS == 0) begin
      pre_d = '0;
      step  = run_s;
    end else begin
      step = run_s && (pre_q == '1);
      if (run_s) pre_d = pre_q + 1'b1;
    end
  end

  // Next-state for the pattern; nothing moves except on a step
  always_comb begin
    cnt_d   = cnt_q;
    pos_d   = pos_q;
    dir_d   = dir_q;
    m_d     = m_q;
    led_d   = led_q;
    tick_d  = 1'b0;
    cnt_inc = cnt_q + 1'b1;
    cnt_dec = cnt_q - 1'b1;
    if (step) begin
      m_d    = mode_s;
      tick_d = 1'b1;
      case (mode_s)
        M_UP: begin
          cnt_d = cnt_inc;
          led_d = cnt_inc;
        end
        M_DOWN: begin
          cnt_d = cnt_dec;
          led_d = cnt_dec;
        end
        M_GRAY: begin
          cnt_d = cnt_inc;
          led_d = bin2gray(cnt_inc);
        end
        default: begin
          if ((m_q != M_BOUNCE) || (N_LEDS == 1)) begin
            pos_d = '0;
            dir_d = DIR_UP;
          end else if (dir_q == DIR_UP) begin
            if (pos_q == POS_MAX) begin
              dir_d = DIR_DN;
              pos_d = pos_q - 1'b1;
            end else begin
              pos_d = pos_q + 1'b1;
            end
          end else begin
            if (pos_q == '0) begin
              dir_d = DIR_UP;
              pos_d = pos_q + 1'b1;
            end else begin
              pos_d = pos_q - 1'b1;
            end
          end
          led_d = onehot(pos_d);
        end
      endcase
    end
  end

  always_ff @(posedge pG0) begin
    if (!p3B2) begin
      run_sync_q  <= '0;
      mode_sync_q <= '0;
      pre_q       <= '0;
      cnt_q       <= '0;
      pos_q       <= '0;
      dir_q       <= DIR_UP;
      m_q         <= M_UP;
      led_q       <= '0;
      tick_q      <= 1'b0;
    end else begin
      run_sync_q  <= run_sync_d;
      mode_sync_q <= mode_sync_d;
      pre_q       <= pre_d;
      cnt_q       <= cnt_d;
      pos_q       <= pos_d;
      dir_q       <= dir_d;
      m_q         <= m_d;
      led_q       <= led_d;
      tick_q      <= tick_d;
    end
  end

  assign led  = led_q;
  assign tick = tick_q;

endmodule
